sample_rle_encoder: RTL and testbench
=====================================

SAMPLE_RLE_ENCODER -- requirements
Module: sample_rle_encoder

Interface
REQ-001 Parameter W, default 16, meaning sample word width in bits; legal range is 4 or more.
REQ-002 Parameter DEPTH, default 8, meaning output FIFO depth in words; must be a power of 2 and at least 4.
REQ-003 Port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-005 Port clear, input, 1 bit: synchronous pulse that empties the FIFO and returns the encoder to IDLE.
REQ-006 Port in_data, input, W bits: sample word.
REQ-007 Port in_valid, input, 1 bit: in_data is valid.
REQ-008 Port in_ready, output, 1 bit: the encoder accepts a word in any cycle where in_valid && in_ready.
REQ-009 Port flush, input, 1 bit: pulse that terminates any open run.
REQ-010 Port out_data, output, W bits: encoded word at the FIFO head.
REQ-011 Port out_valid, output, 1 bit: out_data is valid.
REQ-012 Port out_ready, input, 1 bit: the sink pops the head word when out_valid && out_ready.

Function
REQ-013 The encoder SHALL implement states IDLE, SINGLE and RUN, plus a W-bit last-word register and a W-bit run counter cnt.
REQ-014 IDLE, accepted word w: push w, set last=w, go to SINGLE.
REQ-015 SINGLE, accepted w: push w; if w==last, go to RUN with cnt=0; in all cases set last=w.
REQ-016 RUN, accepted w==last: if cnt==2^W-2, push all-ones (run marker) and set cnt=0; otherwise cnt=cnt+1.
REQ-017 RUN, accepted w!=last: push cnt, then push w in the same cycle (cnt first); set last=w; go to SINGLE.
REQ-018 flush in RUN SHALL push cnt and go to IDLE; flush in SINGLE or IDLE SHALL go to IDLE with no push.
REQ-019 in_ready SHALL equal !flush && !clear && (FIFO free slots >= 2), using registered occupancy.
REQ-020 The FIFO SHALL accept 0, 1 or 2 writes per cycle and 1 read per cycle, with push and pop allowed in the same cycle.
REQ-021 out_valid SHALL equal FIFO non-empty.
REQ-022 A word pushed at edge N SHALL be visible on out_data from cycle N+1 when the FIFO was empty.
REQ-023 The FIFO SHALL never overflow or underflow.
REQ-024 Pointers SHALL wrap modulo DEPTH.
REQ-025 clear SHALL take priority over flush, and flush SHALL take priority over input acceptance.

Reset
REQ-026 While rst_n is low: state=IDLE, FIFO empty, out_valid=0, in_ready=0, cnt=0.
REQ-027 last and out_data SHALL be don't-care during reset.
REQ-028 Reset asserted mid-run SHALL discard the open run without emitting a count.

Configuration
REQ-029 When SAMPLE_RLE_STATS_EN is defined, the block SHALL add two 32-bit outputs, stat_in_words (accepted words) and stat_out_words (popped words).
REQ-030 With SAMPLE_RLE_STATS_EN defined, both counters SHALL wrap, and SHALL reset to 0 on rst_n low or on clear.
REQ-031 When SAMPLE_RLE_STATS_EN is undefined, these ports and counters SHALL NOT exist, and encoding behaviour SHALL be identical to the defined case.

Structure
REQ-032 Package sample_pkg SHALL hold the state encoding constants (IDLE=0, SINGLE=1, RUN=2) and the run-marker definition (all-ones of W bits).
REQ-033 The FIFO SHALL be implemented as sub-module sample_fifo2w, parametrised by W and DEPTH, with a dual-write port and show-ahead read.

Verification (W=16, DEPTH=8, out_ready=1 unless stated)
REQ-034 Scenario distinct words: in 0x0001, 0x0002, 0x0003 -> out 0x0001, 0x0002, 0x0003.
REQ-035 Scenario short run: in A, A, A, A, B (A=0x1234, B=0x5678) -> out A, A, 0x0002, B.
REQ-036 Scenario long run: in A repeated 65537 times, then B -> out A, A, 0xFFFF, 0x0000, B.
REQ-037 Scenario backpressure: out_ready=0 with distinct words -> 7 words accepted, then in_ready=0; out_ready=1 -> all 7 drain in order and in_ready returns to 1.
REQ-038 Scenario flush: in A, A, A, then flush -> out A, A, 0x0001; a following A -> A only, with no count.
REQ-039 Scenario reset and clear mid-run: in A, A, A, then rst_n low (or clear) -> out_valid=0 and no count emitted; a following B -> B.

Source files
------------

// File: rtl/sample_pkg.sv
// -----------------------------------------------------------------------------
// sample_pkg
// Shared definitions for the sample run-length encoder:
//   - state_t : encoder state encoding (IDLE=0, SINGLE=1, RUN=2)
//   - RUN_MARKER_BIT : fill bit of the run marker; the marker is W copies of
//     it (all-ones), and it is emitted when a run counter saturates.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package sample_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  // Run marker = {W{RUN_MARKER_BIT}}, i.e. all-ones at any word width.
  localparam logic RUN_MARKER_BIT = 1'b1;

endpackage

// File: rtl/sample_fifo2w.sv
// -----------------------------------------------------------------------------
// sample_fifo2w
// Show-ahead FIFO with a dual write port: 0, 1 or 2 words written per cycle
// (word 0 lands ahead of word 1) and at most one word read per cycle.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_clear        : synchronous empty; overrides writes and reads
//   i_wr0/i_wr_data0 : first write slot
//   i_wr1/i_wr_data1 : second write slot, only meaningful with i_wr0 set
//   i_rd           : pop the head word (ignored when empty)
//   o_rd_data      : head word (show-ahead)
//   o_empty        : FIFO holds no words
//   o_free         : number of free slots, from registered occupancy
// The writer is responsible for never exceeding o_free.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sample_fifo2w #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_wr0,
  input  logic [W-1:0]           i_wr_data0,
  input  logic                   i_wr1,
  input  logic [W-1:0]           i_wr_data1,
  input  logic                   i_rd,
  output logic [W-1:0]           o_rd_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_free
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_pop;
  logic [AW:0]   w_n_wr;

  assign w_pop  = i_rd && (r_count != '0);
  assign w_n_wr = (AW+1)'(i_wr0) + (AW+1)'(i_wr1);

  // NOTE: storage has no reset; only pointers and occupancy define validity,
  // so resetting the array would cost flops and buy nothing.
  always_ff @(posedge clk) begin
    if (!i_clear) begin
      if (i_wr0) r_mem[r_wr_ptr]          <= i_wr_data0;
      if (i_wr1) r_mem[r_wr_ptr + AW'(1)] <= i_wr_data1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      r_wr_ptr <= r_wr_ptr + w_n_wr[AW-1:0];
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= r_count + w_n_wr - (AW+1)'(w_pop);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_free    = (AW+1)'(DEPTH) - r_count;

endmodule

// File: rtl/sample_rle_encoder.sv
// -----------------------------------------------------------------------------
// sample_rle_encoder
// Run-length encoder for a stream of W-bit samples. The first two copies of a
// repeated word pass through; the run is then closed by a count of further
// repeats (emitted before the next distinct word, or on flush). A saturated
// count is emitted as the all-ones run marker and counting restarts at 0.
// Encoded words are buffered in a sample_fifo2w output FIFO.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous: empty FIFO, return to IDLE
//   in_data/in_valid/in_ready : sample input handshake
//   flush               : close any open run (emits its count)
//   out_data/out_valid/out_ready : encoded output handshake (show-ahead)
// Optional (macro SAMPLE_RLE_STATS_EN):
//   stat_in_words       : wrapping count of accepted input words
//   stat_out_words      : wrapping count of popped output words
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sample_rle_encoder
  import sample_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
`ifdef SAMPLE_RLE_STATS_EN
  ,
  output logic [31:0]  stat_in_words,
  output logic [31:0]  stat_out_words
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [W-1:0] RUN_MARKER = {W{RUN_MARKER_BIT}};
  // Count value at which the next repeat saturates into a marker (2^W-2).
  localparam logic [W-1:0] CNT_LAST   = {{(W-1){RUN_MARKER_BIT}}, 1'b0};

  state_t        r_state;
  logic [W-1:0]  r_last;
  logic [W-1:0]  r_cnt;
  logic          r_live;

  logic          w_accept;
  logic          w_match;
  logic          w_wr0;
  logic          w_wr1;
  logic [W-1:0]  w_wr_data0;
  logic [W-1:0]  w_wr_data1;
  logic          w_empty;
  logic [CW-1:0] w_free;

  // Two free slots are required because a run break pushes count + word.
  // r_live holds in_ready low until the first edge after reset release.
  assign in_ready = r_live && !flush && !clear && (w_free >= CW'(2));
  assign w_accept = in_valid && in_ready;
  assign w_match  = (in_data == r_last);

  // NOTE: every output of this block gets a default first, so no path
  // through the branches can leave a value held (no latch).
  always_comb begin
    w_wr0      = 1'b0;
    w_wr1      = 1'b0;
    w_wr_data0 = in_data;
    w_wr_data1 = in_data;
    if (flush && !clear) begin
      if (r_state == RUN) begin
        w_wr0      = 1'b1;
        w_wr_data0 = r_cnt;
      end
    end else if (w_accept) begin
      case (r_state)
        IDLE, SINGLE: w_wr0 = 1'b1;
        RUN: begin
          if (!w_match) begin
            w_wr0      = 1'b1;
            w_wr1      = 1'b1;
            w_wr_data0 = r_cnt;
          end else if (r_cnt == CNT_LAST) begin
            w_wr0      = 1'b1;
            w_wr_data0 = RUN_MARKER;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (clear || flush) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (w_accept) begin
        case (r_state)
          IDLE: r_state <= SINGLE;
          SINGLE: begin
            if (w_match) begin
              r_state <= RUN;
              r_cnt   <= '0;
            end
          end
          RUN: begin
            if (!w_match)              r_state <= SINGLE;
            else if (r_cnt == CNT_LAST) r_cnt  <= '0;
            else                        r_cnt  <= r_cnt + W'(1);
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Last word is only compared after at least one accept since IDLE.
  always_ff @(posedge clk) begin
    if (w_accept) r_last <= in_data;
  end

  sample_fifo2w #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (clear),
    .i_wr0      (w_wr0),
    .i_wr_data0 (w_wr_data0),
    .i_wr1      (w_wr1),
    .i_wr_data1 (w_wr_data1),
    .i_rd       (out_ready),
    .o_rd_data  (out_data),
    .o_empty    (w_empty),
    .o_free     (w_free)
  );

  assign out_valid = !w_empty;

`ifdef SAMPLE_RLE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_in_words  <= '0;
      stat_out_words <= '0;
    end else if (clear) begin
      stat_in_words  <= '0;
      stat_out_words <= '0;
    end else begin
      if (w_accept)              stat_in_words  <= stat_in_words + 32'd1;
      if (out_valid && out_ready) stat_out_words <= stat_out_words + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_rle_encoder.sv
`timescale 1ns/1ps

module tb_sample_rle_encoder;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam logic [W-1:0] A = 16'h1234;
  localparam logic [W-1:0] B = 16'h5678;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         clear     = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic         flush     = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
`ifdef SAMPLE_RLE_STATS_EN
  logic [31:0]  stat_in_words;
  logic [31:0]  stat_out_words;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] got [$];

  sample_rle_encoder #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SAMPLE_RLE_STATS_EN
    ,
    .stat_in_words  (stat_in_words),
    .stat_out_words (stat_out_words)
`endif
  );

  always #5 clk = ~clk;

  // A word seen valid+ready at the negedge is popped at the following posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one word and hold it until accepted; bounded wait.
  task automatic send(input logic [W-1:0] w);
    int t;
    t        = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 64) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_assert++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1 (word %h)", t, w);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Wait n cycles; returns just after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Clean starting point for a scenario: IDLE encoder, empty FIFO, empty log.
  task automatic start_scenario();
    idle(2);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    got.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    n_assert++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_in_ready: got %b, required 1", in_ready);
    end
    n_assert++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_out_valid: got %b, required 0", out_valid);
    end
  endtask

  task automatic test_distinct();
    logic [W-1:0] exp [$];
    exp = '{16'h0001, 16'h0002, 16'h0003};
    start_scenario();
    send(16'h0001);
    send(16'h0002);
    send(16'h0003);
    idle(10);
    n_assert++;
    if (got.size() != exp.size()) begin
      n_fail++;
      $display("FAIL distinct_len: got %0d words, required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_assert++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL distinct[%0d]: got %h, required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_short_run();
    logic [W-1:0] exp [$];
    exp = '{A, A, 16'h0002, B};
    start_scenario();
    repeat (4) send(A);
    send(B);
    idle(10);
    n_assert++;
    if (got.size() != exp.size()) begin
      n_fail++;
      $display("FAIL short_run_len: got %0d words, required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_assert++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL short_run[%0d]: got %h, required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_long_run();
    logic [W-1:0] exp [$];
    exp = '{A, A, 16'hFFFF, 16'h0000, B};
    start_scenario();
    for (int i = 0; i < 65537; i++) send(A);
    send(B);
    idle(10);
    n_assert++;
    if (got.size() != exp.size()) begin
      n_fail++;
      $display("FAIL long_run_len: got %0d words, required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_assert++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL long_run[%0d]: got %h, required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    start_scenario();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(16'h0100 + 16'(i));
    @(negedge clk);
    n_assert++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full_in_ready: got %b, required 0", in_ready);
    end
    n_assert++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full_out_valid: got %b, required 1", out_valid);
    end
    // An eighth word is offered but must not be taken while full.
    @(posedge clk);
    #1;
    in_data  = 16'h0BAD;
    in_valid = 1'b1;
    idle(4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(15);
    n_assert++;
    if (got.size() != 7) begin
      n_fail++;
      $display("FAIL bp_drain_len: got %0d words, required 7", got.size());
    end
    for (int i = 0; i < 7; i++) begin
      n_assert++;
      if (i >= got.size() || got[i] !== 16'h0100 + 16'(i)) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: got %h, required %h", i, got[i], 16'h0100 + 16'(i));
      end
    end
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_in_ready_back: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] exp [$];
    exp = '{A, A, 16'h0001, A};
    start_scenario();
    repeat (3) send(A);
    flush = 1'b1;
    @(negedge clk);
    n_assert++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_in_ready: got %b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    send(A);
    idle(10);
    n_assert++;
    if (got.size() != exp.size()) begin
      n_fail++;
      $display("FAIL flush_len: got %0d words, required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_assert++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL flush[%0d]: got %h, required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    // Reset variant: open run (A,A,A) is discarded.
    start_scenario();
    repeat (3) send(A);
    idle(3);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset_out_valid: got %b, required 0", out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(B);
    idle(10);
    n_assert++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL midrun_reset_len: got %0d words, required 3", got.size());
    end
    n_assert++;
    if (got.size() < 3 || got[0] !== A || got[1] !== A || got[2] !== B) begin
      n_fail++;
      $display("FAIL midrun_reset_data: got %h %h %h, required %h %h %h",
               got[0], got[1], got[2], A, A, B);
    end

    // Clear variant.
    start_scenario();
    repeat (3) send(A);
    idle(3);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    n_assert++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_clear_out_valid: got %b, required 0", out_valid);
    end
    idle(2);
    send(B);
    idle(10);
    n_assert++;
    if (got.size() != 3 || got[2] !== B || got[0] !== A || got[1] !== A) begin
      n_fail++;
      $display("FAIL midrun_clear_data: got %0d words (last %h), required 3 words A A B",
               got.size(), got[got.size()-1]);
    end
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_short_run();
    test_backpressure();
    test_flush();
    test_reset_mid_run();
    test_long_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
